// File: rtl/noc_tx_engine_pkg.sv
// Shared NoC definitions: flit geometry, router port indices, TX engine state encoding.
package noc_tx_engine_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 256;
  localparam int unsigned NOC_COORD_BITS = 4;
  localparam int unsigned FLIT_WIDTH     = NOC_DATA_WIDTH + 2 * NOC_COORD_BITS;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_NORTH = 1;
  localparam int unsigned PORT_EAST  = 2;
  localparam int unsigned PORT_SOUTH = 3;
  localparam int unsigned PORT_WEST  = 4;
  localparam int unsigned NUM_PORTS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push is dropped when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are only observed behind a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/noc_tx_engine.sv
// NoC transmit engine: reads a burst of local memory words and emits them as flits.
module noc_tx_engine
  import noc_tx_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned COORD_BITS = 4,
  parameter int unsigned LEN_BITS   = 8,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [COORD_BITS-1:0] cmd_dest_x,
  input  logic [COORD_BITS-1:0] cmd_dest_y,
  input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [LEN_BITS-1:0]   cmd_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [COORD_BITS-1:0] out_dest_x,
  output logic [COORD_BITS-1:0] out_dest_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  tx_state_e             state;
  logic [LEN_BITS-1:0]   rd_left;
  logic [LEN_BITS-1:0]   left_nxt;
  logic [CNT_W-1:0]      pend;
  logic [CNT_W-1:0]      pend_nxt;
  logic                  wr_pend;
  logic                  xfer;
  logic                  room;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  // Flit buffer; read data lands one cycle after its strobe.
  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_pend),
    .push_data (mem_rd_data),
    .pop       (xfer),
    .pop_data  (fifo_head),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;

  // Next-cycle credit: pend counts reads issued but not yet sent as flits.
  always_comb begin
    xfer     = out_valid && out_ready;
    pend_nxt = pend + CNT_W'(mem_rd_en) - CNT_W'(xfer);
    left_nxt = rd_left - LEN_BITS'(mem_rd_en);
    room     = pend_nxt < CNT_W'(BUF_DEPTH);
  end

  // Control FSM with registered strobes, address generator and credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_dest_x  <= '0;
      out_dest_y  <= '0;
      rd_left     <= '0;
      pend        <= '0;
      wr_pend     <= 1'b0;
    end else begin
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      wr_pend     <= mem_rd_en;
      pend        <= pend_nxt;
      rd_left     <= left_nxt;
      mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(mem_rd_en);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            out_dest_x  <= cmd_dest_x;
            out_dest_y  <= cmd_dest_y;
            mem_rd_addr <= cmd_src_addr;
            rd_left     <= cmd_len;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            if (cmd_len != '0) begin
              state     <= ST_ISSUE;
              mem_rd_en <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (left_nxt == '0) begin
            state <= ST_DRAIN;
          end else begin
            mem_rd_en <= room;
          end
        end
        ST_DRAIN: begin
          if (pend_nxt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_tx_engine.sv
// Self-checking bench for noc_tx_engine against a transaction-level model.
module tb_noc_tx_engine;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 20;
  localparam int unsigned CB = 4;
  localparam int unsigned LB = 8;
  localparam int unsigned BD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CB-1:0] cmd_dest_x, cmd_dest_y;
  logic [AW-1:0] cmd_src_addr;
  logic [LB-1:0] cmd_len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic [CB-1:0] out_dest_x, out_dest_y;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  noc_tx_engine #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .COORD_BITS (CB), .LEN_BITS (LB), .BUF_DEPTH (BD)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_dest_x (cmd_dest_x), .cmd_dest_y (cmd_dest_y),
    .cmd_src_addr (cmd_src_addr), .cmd_len (cmd_len),
    .mem_rd_en (mem_rd_en), .mem_rd_addr (mem_rd_addr), .mem_rd_data (mem_rd_data),
    .out_data (out_data), .out_dest_x (out_dest_x), .out_dest_y (out_dest_y),
    .out_valid (out_valid), .out_ready (out_ready),
    .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content is a recognisable function of the word address.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{{12'hD5A, a}}};
  endfunction

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Local memory: data for a strobed address appears the following cycle, junk otherwise.
  logic [31:0] junk;
  always @(posedge clk) begin
    junk = $urandom;
    if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);
    else           mem_rd_data <= {8{junk}};
  end

  // Router backpressure pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Transaction model state.
  bit            m_busy = 0, m_done_now = 0, m_seen_v = 0, p_stall = 0;
  int            m_len = 0, m_issued = 0, m_sent = 0, m_acc = -100;
  logic [AW-1:0] m_src = '0;
  logic [CB-1:0] m_dx = '0, m_dy = '0;
  logic [DW-1:0] p_data;
  int            obs_acc[$], obs_done[$], obs_xfer[$];
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_first;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    bit nb, nd;
    if (!rst_n) begin
      check(!out_valid && !mem_rd_en && !done && !busy, "reset_ctrl",
            {out_valid, mem_rd_en, done, busy}, 0);
      check(out_data == '0 && out_dest_x == '0 && out_dest_y == '0, "reset_data", out_data, 0);
      m_busy = 0; m_done_now = 0; m_seen_v = 0; p_stall = 0;
      m_len = 0; m_issued = 0; m_sent = 0;
    end else begin
      check(busy == m_busy, "busy", busy, m_busy);
      check(cmd_ready == !m_busy, "cmd_ready", cmd_ready, !m_busy);
      check(done == m_done_now, "done", done, m_done_now);
      if (m_done_now) obs_done.push_back(cyc);
      if (mem_rd_en) begin
        check(m_busy && m_issued < m_len, "rd_unexpected", m_issued, m_len);
        check(m_issued - m_sent < BD, "rd_credit", m_issued - m_sent, BD);
        if (m_issued == 0) check(cyc == m_acc + 1, "rd_latency", cyc, m_acc + 1);
        check(mem_rd_addr == m_src + AW'(m_issued), "rd_addr", mem_rd_addr, m_src + AW'(m_issued));
        obs_addr.push_back(mem_rd_addr);
        m_issued++;
      end
      if (p_stall) check(out_valid && out_data == p_data, "stall_stable", out_data, p_data);
      if (out_valid) begin
        check(m_busy && m_sent < m_len, "valid_unexpected", m_sent, m_len);
        check(out_data == pat(m_src + AW'(m_sent)), "flit_data", out_data, pat(m_src + AW'(m_sent)));
        check(out_dest_x == m_dx && out_dest_y == m_dy, "flit_dest", {out_dest_x, out_dest_y}, {m_dx, m_dy});
        if (!m_seen_v) check(cyc == m_acc + 3, "valid_latency", cyc, m_acc + 3);
        m_seen_v = 1;
        if (out_ready) begin
          obs_xfer.push_back(cyc);
          if (m_sent == 0) obs_first = out_data[31:0];
          m_sent++;
        end
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      nb = m_busy;
      nd = 0;
      if (m_done_now) nb = 0;
      else if (m_busy && m_len != 0 && out_valid && out_ready && m_sent == m_len) nd = 1;
      if (!m_busy && cmd_valid) begin
        nb = 1; nd = (cmd_len == '0);
        m_len = int'(cmd_len); m_src = cmd_src_addr; m_dx = cmd_dest_x; m_dy = cmd_dest_y;
        m_issued = 0; m_sent = 0; m_seen_v = 0; m_acc = cyc;
        obs_acc.push_back(cyc);
      end
      m_busy = nb;
      m_done_now = nd;
    end
  end

  task automatic clear_obs();
    obs_acc.delete(); obs_done.delete(); obs_xfer.delete(); obs_addr.delete();
  endtask

  task automatic send(input logic [CB-1:0] x, input logic [CB-1:0] y,
                      input logic [AW-1:0] a, input logic [LB-1:0] l);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dest_x = x; cmd_dest_y = y; cmd_src_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk); #2;
    while (m_busy && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check(!m_busy, "idle_timeout", n, budget);
  endtask

  logic [AW-1:0] exp_wrap [4];

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dest_x = '0; cmd_dest_y = '0;
    cmd_src_addr = '0; cmd_len = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic burst at full rate.
    rdy_mode = 0;
    clear_obs();
    send(4'd2, 4'd1, 20'h00100, 8'd4);
    wait_idle(100);
    check(obs_xfer.size() == 4, "t1_count", obs_xfer.size(), 4);
    if (obs_xfer.size() == 4 && obs_acc.size() == 1)
      for (int k = 0; k < 4; k++)
        check(obs_xfer[k] == obs_acc[0] + 3 + k, "t1_xfer_cycle", obs_xfer[k], obs_acc[0] + 3 + k);
    check(obs_done.size() == 1 && obs_acc.size() == 1 && obs_done[0] == obs_acc[0] + 7,
          "t1_done_cycle", obs_done.size(), 1);
    check(obs_first == 32'hD5A00100, "t1_first_word", obs_first, 32'hD5A00100);

    // Alternating backpressure.
    rdy_mode = 1;
    clear_obs();
    send(4'd5, 4'd7, 20'h0ABC0, 8'd8);
    wait_idle(200);
    check(obs_xfer.size() == 8, "t2_count", obs_xfer.size(), 8);
    check(obs_addr.size() == 8, "t2_reads", obs_addr.size(), 8);

    // Zero-length command.
    rdy_mode = 0;
    clear_obs();
    send(4'd1, 4'd1, 20'h00200, 8'd0);
    wait_idle(20);
    check(obs_addr.size() == 0 && obs_xfer.size() == 0, "t3_no_traffic", obs_addr.size(), 0);
    check(obs_done.size() == 1 && obs_acc.size() == 1 && obs_done[0] == obs_acc[0] + 1,
          "t3_done_cycle", obs_done.size(), 1);

    // Address wrap.
    exp_wrap[0] = 20'hFFFFE; exp_wrap[1] = 20'hFFFFF; exp_wrap[2] = 20'h00000; exp_wrap[3] = 20'h00001;
    rdy_mode = 2;
    clear_obs();
    send(4'd3, 4'd2, 20'hFFFFE, 8'd4);
    wait_idle(100);
    check(obs_addr.size() == 4, "t4_reads", obs_addr.size(), 4);
    if (obs_addr.size() == 4)
      for (int k = 0; k < 4; k++)
        check(obs_addr[k] == exp_wrap[k], "t4_wrap_addr", obs_addr[k], exp_wrap[k]);

    // Reset in the middle of a burst, then a fresh command.
    rdy_mode = 0;
    clear_obs();
    send(4'd6, 4'd4, 20'h03000, 8'd6);
    n = 0;
    while (m_sent < 2 && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    check(m_sent == 2, "t5_two_sent", m_sent, 2);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    send(4'd9, 4'd8, 20'h04440, 8'd2);
    wait_idle(100);
    check(obs_xfer.size() == 2, "t5_after_reset", obs_xfer.size(), 2);

    // Command held valid across a busy period.
    clear_obs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dest_x = 4'd1; cmd_dest_y = 4'd3; cmd_src_addr = 20'h00040; cmd_len = 8'd3;
    @(posedge clk); #1;
    cmd_dest_x = 4'd3; cmd_dest_y = 4'd0; cmd_src_addr = 20'h00080; cmd_len = 8'd2;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle(100);
    check(obs_acc.size() == 2 && obs_done.size() == 2 && obs_acc[1] == obs_done[0] + 1,
          "t6_second_accept", obs_acc.size(), 2);
    check(obs_xfer.size() == 5, "t6_flits", obs_xfer.size(), 5);

    // Randomized traffic.
    rdy_mode = 2;
    repeat (600) begin
      @(posedge clk); #1;
      cmd_valid    = ($urandom_range(0, 4) == 0);
      cmd_len      = LB'($urandom_range(0, 10));
      cmd_src_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom) : 20'hFFFFA + AW'($urandom_range(0, 5));
      cmd_dest_x   = CB'($urandom);
      cmd_dest_y   = CB'($urandom);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
